// File: rtl/iob_split_ot.sv
`default_nettype none
// ============================================================================
//  Module      : iob_split_ot
//  Description : IOb-native 1-master to N-slave splitter. Tracks up to MAX_OUT
//                in-flight reads to a single slave and stalls target switches
//                until they drain, so read data returns in order. Out-of-range
//                selects go to an internal error slave.
//  Revision    : 1.0 - initial release
// ============================================================================
module iob_split_ot #(
    parameter int                DATA_W   = 32,
    parameter int                ADDR_W   = 32,
    parameter int                N_SLAVES = 2,
    parameter int                P_SLAVES = ADDR_W - 1,
    parameter int                MAX_OUT  = 4,
    parameter logic [DATA_W-1:0] ERR_DATA = {DATA_W{1'b1}}
) (
    input  logic                           clk_i,
    input  logic                           cke_i,
    input  logic                           arst_n_i,
    input  logic                           m_avalid_i,
    input  logic [ADDR_W-1:0]              m_addr_i,
    input  logic [DATA_W-1:0]              m_wdata_i,
    input  logic [DATA_W/8-1:0]            m_wstrb_i,
    output logic                           m_ready_o,
    output logic                           m_rvalid_o,
    output logic [DATA_W-1:0]              m_rdata_o,
    output logic [N_SLAVES-1:0]            s_avalid_o,
    output logic [N_SLAVES*ADDR_W-1:0]     s_addr_o,
    output logic [N_SLAVES*DATA_W-1:0]     s_wdata_o,
    output logic [N_SLAVES*DATA_W/8-1:0]   s_wstrb_o,
    input  logic [N_SLAVES-1:0]            s_ready_i,
    input  logic [N_SLAVES-1:0]            s_rvalid_i,
    input  logic [N_SLAVES*DATA_W-1:0]     s_rdata_i,
    output logic                           perr_o
);

    localparam int            NB    = (N_SLAVES > 1) ? $clog2(N_SLAVES) : 1;
    localparam int            TW    = NB + 1;
    localparam int            CW    = $clog2(MAX_OUT + 1);
    localparam int            SW    = DATA_W / 8;
    // Target index one past the last real slave is the internal error slave
    localparam logic [TW-1:0] ERR_T = TW'(N_SLAVES);
    localparam logic [CW-1:0] FULL  = CW'(MAX_OUT);

    logic [CW-1:0]     cnt;
    logic [TW-1:0]     cur_t;
    logic              err_q;
    logic              perr;

    logic [NB-1:0]     sel;
    logic [TW-1:0]     tgt;
    logic              tgt_err;
    logic              cur_err;
    logic              stall;
    logic              sel_ready;
    logic              cur_rvalid;
    logic [DATA_W-1:0] cur_rdata;
    logic              stray;
    logic              rsp;
    logic              acc;
    logic              rd;

    assign sel     = m_addr_i[P_SLAVES -: NB];
    assign tgt     = ({1'b0, sel} < ERR_T) ? {1'b0, sel} : ERR_T;
    assign tgt_err = (tgt == ERR_T);
    assign cur_err = (cur_t == ERR_T);

    // Switching target is held off while reads are in flight so responses
    // cannot overtake each other; a full tracker also stalls, with no bypass
    assign stall = ((cnt != '0) && (tgt != cur_t)) || (cnt == FULL);

    // Pick ready of the addressed slave and response of the in-flight target;
    // any rvalid not belonging to the in-flight target is flagged as stray
    always_comb begin
        sel_ready  = 1'b0;
        cur_rvalid = 1'b0;
        cur_rdata  = '0;
        stray      = 1'b0;
        for (int i = 0; i < N_SLAVES; i++) begin
            if (tgt == TW'(i)) begin
                sel_ready = s_ready_i[i];
            end
            if (cur_t == TW'(i)) begin
                cur_rvalid = s_rvalid_i[i];
                cur_rdata  = s_rdata_i[i*DATA_W +: DATA_W];
            end
            if (s_rvalid_i[i] && ((cnt == '0) || (cur_t != TW'(i)))) begin
                stray = 1'b1;
            end
        end
    end

    // Request fan-out: only the addressed slave sees the request fields
    for (genvar i = 0; i < N_SLAVES; i++) begin : g_slave
        logic hit;
        assign hit                        = (tgt == TW'(i));
        assign s_avalid_o[i]              = m_avalid_i & ~stall & hit;
        assign s_addr_o[i*ADDR_W +: ADDR_W] = hit ? m_addr_i  : '0;
        assign s_wdata_o[i*DATA_W +: DATA_W] = hit ? m_wdata_i : '0;
        assign s_wstrb_o[i*SW +: SW]      = hit ? m_wstrb_i : '0;
    end

    // The error slave is always ready; it never backpressures
    assign m_ready_o = ~stall & (tgt_err | sel_ready);
    assign acc       = m_avalid_i & m_ready_o;
    assign rd        = acc & (m_wstrb_i == '0);

    assign rsp        = (cnt != '0) & (cur_err ? err_q : cur_rvalid);
    assign m_rvalid_o = rsp;
    assign m_rdata_o  = !rsp ? '0 : (cur_err ? ERR_DATA : cur_rdata);
    assign perr_o     = perr;

    // Outstanding-read tracking and sticky error flag, all frozen by cke_i
    always_ff @(posedge clk_i or negedge arst_n_i) begin
        if (!arst_n_i) begin
            cnt   <= '0;
            cur_t <= '0;
            err_q <= 1'b0;
            perr  <= 1'b0;
        end else if (cke_i) begin
            cnt   <= cnt + CW'(rd) - CW'(rsp);
            err_q <= rd & tgt_err;
            if (rd) begin
                cur_t <= tgt;
            end
            if ((acc & tgt_err) | stray) begin
                perr <= 1'b1;
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_iob_split_ot.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
//  Module      : tb_iob_split_ot
//  Description : Self-checking bench for iob_split_ot with a latency-based
//                slave model and a read-data scoreboard.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_iob_split_ot;

    localparam int LAT = 3;

    logic        clk = 1'b0;
    logic        cke, arst_n;
    logic        m_avalid;
    logic [31:0] m_addr, m_wdata;
    logic [3:0]  m_wstrb;
    logic        m_ready, m_rvalid;
    logic [31:0] m_rdata;
    logic [1:0]  s_avalid;
    logic [63:0] s_addr, s_wdata;
    logic [7:0]  s_wstrb;
    logic [1:0]  s_ready, s_rvalid;
    logic [63:0] s_rdata;
    logic        perr;

    logic [1:0]  mdl_rv, stray, slv_en;
    logic [31:0] mdl_rd0, mdl_rd1;

    // Three-slave instance for decode-error checks
    logic        m_avalid3;
    logic [31:0] m_addr3;
    logic [31:0] m_wdata3;
    logic [3:0]  m_wstrb3;
    logic        m_ready3, m_rvalid3;
    logic [31:0] m_rdata3;
    logic [2:0]  s_avalid3;
    logic [95:0] s_addr3, s_wdata3;
    logic [11:0] s_wstrb3;
    logic [2:0]  s_ready3, s_rvalid3;
    logic [95:0] s_rdata3;
    logic        perr3;

    int tests_run = 0;
    int fails     = 0;
    logic [31:0] exp_q[$];

    always #5 clk = ~clk;

    assign s_ready   = 2'b11;
    assign s_rvalid  = mdl_rv | stray;
    assign s_rdata   = {mdl_rd1, mdl_rd0};
    assign s_ready3  = 3'b111;
    assign s_rvalid3 = 3'b000;
    assign s_rdata3  = '0;
    assign m_wdata3  = 32'h0;

    iob_split_ot dut (
        .clk_i(clk), .cke_i(cke), .arst_n_i(arst_n),
        .m_avalid_i(m_avalid), .m_addr_i(m_addr), .m_wdata_i(m_wdata), .m_wstrb_i(m_wstrb),
        .m_ready_o(m_ready), .m_rvalid_o(m_rvalid), .m_rdata_o(m_rdata),
        .s_avalid_o(s_avalid), .s_addr_o(s_addr), .s_wdata_o(s_wdata), .s_wstrb_o(s_wstrb),
        .s_ready_i(s_ready), .s_rvalid_i(s_rvalid), .s_rdata_i(s_rdata),
        .perr_o(perr)
    );

    iob_split_ot #(.N_SLAVES(3), .P_SLAVES(31)) dut3 (
        .clk_i(clk), .cke_i(cke), .arst_n_i(arst_n),
        .m_avalid_i(m_avalid3), .m_addr_i(m_addr3), .m_wdata_i(m_wdata3), .m_wstrb_i(m_wstrb3),
        .m_ready_o(m_ready3), .m_rvalid_o(m_rvalid3), .m_rdata_o(m_rdata3),
        .s_avalid_o(s_avalid3), .s_addr_o(s_addr3), .s_wdata_o(s_wdata3), .s_wstrb_o(s_wstrb3),
        .s_ready_i(s_ready3), .s_rvalid_i(s_rvalid3), .s_rdata_i(s_rdata3),
        .perr_o(perr3)
    );

    function automatic logic [31:0] rsp_data(input logic [31:0] a);
        return a ^ 32'h5EED_0000;
    endfunction

    // ---------------- slave model: fixed latency, one response per cycle ----
    typedef struct { int unsigned due; logic [31:0] data; } pend_t;
    pend_t       pq0[$], pq1[$];
    int unsigned cyc = 0;

    always @(negedge clk) begin
        pend_t e;
        if (arst_n && cke) begin
            if (s_avalid[0] && s_ready[0] && s_wstrb[3:0] == 4'h0) begin
                e.due = cyc + LAT; e.data = rsp_data(s_addr[31:0]); pq0.push_back(e);
            end
            if (s_avalid[1] && s_ready[1] && s_wstrb[7:4] == 4'h0) begin
                e.due = cyc + LAT; e.data = rsp_data(s_addr[63:32]); pq1.push_back(e);
            end
        end
    end

    initial begin
        mdl_rv = 2'b00; mdl_rd0 = '0; mdl_rd1 = '0;
        forever begin
            @(posedge clk); cyc++; #1;
            mdl_rv = 2'b00;
            if (slv_en[0] && pq0.size() > 0 && pq0[0].due <= cyc) begin
                mdl_rv[0] = 1'b1; mdl_rd0 = pq0[0].data; void'(pq0.pop_front());
            end
            if (slv_en[1] && pq1.size() > 0 && pq1[0].due <= cyc) begin
                mdl_rv[1] = 1'b1; mdl_rd1 = pq1[0].data; void'(pq1.pop_front());
            end
        end
    end

    // ---------------- response scoreboard ----------------
    always @(negedge clk) begin
        logic [31:0] e;
        if (m_rvalid) begin
            tests_run++;
            if (exp_q.size() == 0) begin
                fails++;
                $display("FAIL rvalid_unexpected: got rvalid=1 rdata=%h, required no response", m_rdata);
            end else begin
                e = exp_q.pop_front();
                if (m_rdata !== e) begin
                    fails++;
                    $display("FAIL rdata_order: got %h, required %h", m_rdata, e);
                end
            end
        end
    end

    // Issue one request starting at posedge+1; returns cycles waited or -1
    task automatic do_req(input logic [31:0] a, input logic [31:0] wd,
                          input logic [3:0] ws, input int budget, output int waited);
        m_avalid = 1'b1; m_addr = a; m_wdata = wd; m_wstrb = ws;
        waited = -1;
        for (int n = 0; n < budget; n++) begin
            @(negedge clk);
            if (m_ready) begin
                if (ws == 4'h0) exp_q.push_back(rsp_data(a));
                waited = n;
            end
            @(posedge clk); #1;
            if (waited >= 0) break;
        end
        m_avalid = 1'b0; m_wstrb = 4'h0;
    endtask

    task automatic wait_drain(input int budget);
        int n = 0;
        while (exp_q.size() != 0 && n < budget) begin
            @(posedge clk); #1; n++;
        end
        tests_run++;
        if (exp_q.size() != 0) begin
            fails++;
            $display("FAIL drain: %0d responses outstanding, required 0", exp_q.size());
            exp_q.delete();
        end
    endtask

    task automatic test_reset();
        cke = 1'b1; arst_n = 1'b0; stray = 2'b00; slv_en = 2'b11;
        m_avalid = 1'b1; m_addr = 32'h10; m_wdata = 32'h1234_5678; m_wstrb = 4'h0;
        m_avalid3 = 1'b0; m_addr3 = '0; m_wstrb3 = 4'h0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        tests_run++;
        if (m_rvalid !== 1'b0 || m_rdata !== 32'h0 || perr !== 1'b0) begin
            fails++;
            $display("FAIL reset_outputs: rvalid=%b rdata=%h perr=%b, required 0 0 0", m_rvalid, m_rdata, perr);
        end
        tests_run++;
        if (m_ready !== 1'b1 || s_avalid !== 2'b01) begin
            fails++;
            $display("FAIL reset_request: ready=%b s_avalid=%b, required 1 01", m_ready, s_avalid);
        end
        tests_run++;
        if (s_addr !== {32'h0, 32'h10} || s_wdata !== {32'h0, 32'h1234_5678}) begin
            fails++;
            $display("FAIL reset_fields: s_addr=%h s_wdata=%h, required slave0-only fields", s_addr, s_wdata);
        end
        @(posedge clk); #1;
        m_avalid = 1'b0; arst_n = 1'b1;
        @(posedge clk); #1;
    endtask

    task automatic test_back_to_back();
        int w;
        for (int k = 0; k < 4; k++) begin
            do_req(32'h10 + 32'(4 * k), 32'h0, 4'h0, 20, w);
            tests_run++;
            if (w != 0) begin
                fails++;
                $display("FAIL b2b_accept[%0d]: waited %0d cycles, required 0", k, w);
            end
        end
        wait_drain(40);
        do_req(32'h8000_0040, 32'h0, 4'h0, 20, w);
        tests_run++;
        if (w != 0) begin
            fails++;
            $display("FAIL b2b_idle_switch: waited %0d cycles, required 0", w);
        end
        wait_drain(40);
    endtask

    task automatic test_max_out();
        int w;
        slv_en[1] = 1'b0;
        for (int k = 0; k < 4; k++) begin
            do_req(32'h8000_0100 + 32'(4 * k), 32'h0, 4'h0, 20, w);
            tests_run++;
            if (w != 0) begin
                fails++;
                $display("FAIL maxout_accept[%0d]: waited %0d cycles, required 0", k, w);
            end
        end
        m_avalid = 1'b1; m_addr = 32'h8000_0110; m_wstrb = 4'h0;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            tests_run++;
            if (m_ready !== 1'b0 || s_avalid !== 2'b00) begin
                fails++;
                $display("FAIL maxout_hold[%0d]: ready=%b s_avalid=%b, required 0 00", k, m_ready, s_avalid);
            end
            if (k == 2) slv_en[1] = 1'b1;
            @(posedge clk); #1;
        end
        do_req(32'h8000_0110, 32'h0, 4'h0, 10, w);
        tests_run++;
        if (w != 1) begin
            fails++;
            $display("FAIL maxout_release: waited %0d cycles, required 1", w);
        end
        wait_drain(40);
    endtask

    task automatic test_switch();
        int w;
        int rv_seen = -1;
        int acc_at  = -1;
        do_req(32'h20, 32'h0, 4'h0, 20, w);
        tests_run++;
        if (w != 0) begin
            fails++;
            $display("FAIL switch_first: waited %0d cycles, required 0", w);
        end
        m_avalid = 1'b1; m_addr = 32'h8000_0000; m_wstrb = 4'h0;
        for (int n = 0; n < 20; n++) begin
            @(negedge clk);
            if (m_ready) begin
                acc_at = n;
                exp_q.push_back(rsp_data(32'h8000_0000));
            end else begin
                tests_run++;
                if (s_avalid[1] !== 1'b0) begin
                    fails++;
                    $display("FAIL switch_avalid[%0d]: s_avalid[1]=%b, required 0", n, s_avalid[1]);
                end
            end
            if (s_rvalid[0] && rv_seen < 0) rv_seen = n;
            @(posedge clk); #1;
            if (acc_at >= 0) break;
        end
        m_avalid = 1'b0;
        tests_run++;
        if (rv_seen < 0 || acc_at != rv_seen + 1) begin
            fails++;
            $display("FAIL switch_timing: accepted at %0d, slave0 rvalid at %0d, required rvalid+1", acc_at, rv_seen);
        end
        wait_drain(40);
    endtask

    task automatic test_decode_err();
        // Write to slave 2 (sel=2, valid on three slaves)
        m_avalid3 = 1'b1; m_addr3 = 32'h8000_0000; m_wstrb3 = 4'hF;
        @(negedge clk);
        tests_run++;
        if (s_avalid3 !== 3'b100 || m_ready3 !== 1'b1) begin
            fails++;
            $display("FAIL err_slave2: s_avalid=%b ready=%b, required 100 1", s_avalid3, m_ready3);
        end
        @(posedge clk); #1;
        m_addr3 = 32'hC000_0000; m_wstrb3 = 4'h0;
        @(negedge clk);
        tests_run++;
        if (m_ready3 !== 1'b1 || s_avalid3 !== 3'b000 || m_rvalid3 !== 1'b0 || perr3 !== 1'b0) begin
            fails++;
            $display("FAIL err_accept: ready=%b s_avalid=%b rvalid=%b perr=%b, required 1 000 0 0",
                     m_ready3, s_avalid3, m_rvalid3, perr3);
        end
        @(posedge clk); #1;
        m_avalid3 = 1'b0;
        @(negedge clk);
        tests_run++;
        if (m_rvalid3 !== 1'b1 || m_rdata3 !== 32'hFFFF_FFFF || perr3 !== 1'b1) begin
            fails++;
            $display("FAIL err_response: rvalid=%b rdata=%h perr=%b, required 1 ffffffff 1",
                     m_rvalid3, m_rdata3, perr3);
        end
        @(posedge clk); #1;
        @(negedge clk);
        tests_run++;
        if (m_rvalid3 !== 1'b0 || m_rdata3 !== 32'h0 || perr3 !== 1'b1) begin
            fails++;
            $display("FAIL err_after: rvalid=%b rdata=%h perr=%b, required 0 0 1", m_rvalid3, m_rdata3, perr3);
        end
        @(posedge clk); #1;
    endtask

    task automatic test_write_stray();
        int w;
        slv_en[1] = 1'b0;
        do_req(32'h8000_0200, 32'h0, 4'h0, 20, w);
        tests_run++;
        if (w != 0) begin
            fails++;
            $display("FAIL wr_read: waited %0d cycles, required 0", w);
        end
        m_avalid = 1'b1; m_addr = 32'h8000_0204; m_wdata = 32'hDEAD_BEEF; m_wstrb = 4'hF;
        @(negedge clk);
        tests_run++;
        if (m_ready !== 1'b1 || s_avalid !== 2'b10 || s_wdata[63:32] !== 32'hDEAD_BEEF ||
            s_wstrb !== 8'hF0 || perr !== 1'b0) begin
            fails++;
            $display("FAIL wr_accept: ready=%b s_avalid=%b wdata=%h wstrb=%h perr=%b, required 1 10 deadbeef f0 0",
                     m_ready, s_avalid, s_wdata[63:32], s_wstrb, perr);
        end
        @(posedge clk); #1;
        m_avalid = 1'b0; m_wstrb = 4'h0;
        stray = 2'b01;
        @(negedge clk);
        tests_run++;
        if (m_rvalid !== 1'b0) begin
            fails++;
            $display("FAIL stray_forward: rvalid=%b, required 0", m_rvalid);
        end
        @(posedge clk); #1;
        stray = 2'b00;
        @(negedge clk);
        tests_run++;
        if (perr !== 1'b1) begin
            fails++;
            $display("FAIL stray_perr: perr=%b, required 1", perr);
        end
        slv_en[1] = 1'b1;
        @(posedge clk); #1;
        wait_drain(40);
        do_req(32'h30, 32'h0, 4'h0, 20, w);
        tests_run++;
        if (w != 0) begin
            fails++;
            $display("FAIL wr_cnt_unchanged: waited %0d cycles, required 0", w);
        end
        wait_drain(40);
    endtask

    task automatic test_reset_mid();
        int w;
        int seen = 0;
        slv_en[0] = 1'b0;
        do_req(32'h300, 32'h0, 4'h0, 20, w);
        do_req(32'h304, 32'h0, 4'h0, 20, w);
        arst_n = 1'b0;
        exp_q.delete();
        m_avalid = 1'b1; m_addr = 32'h8000_0000; m_wstrb = 4'h0;
        @(negedge clk);
        tests_run++;
        if (perr !== 1'b0 || m_ready !== 1'b1 || m_rvalid !== 1'b0) begin
            fails++;
            $display("FAIL rst_mid: perr=%b ready=%b rvalid=%b, required 0 1 0", perr, m_ready, m_rvalid);
        end
        @(posedge clk); #1;
        m_avalid = 1'b0; arst_n = 1'b1;
        @(negedge clk);
        slv_en[0] = 1'b1;
        for (int n = 0; n < 10; n++) begin
            @(negedge clk);
            if (s_rvalid[0]) begin
                seen++;
                tests_run++;
                if (m_rvalid !== 1'b0) begin
                    fails++;
                    $display("FAIL late_forward: rvalid=%b, required 0", m_rvalid);
                end
            end
        end
        tests_run++;
        if (seen != 2 || perr !== 1'b1) begin
            fails++;
            $display("FAIL late_perr: late responses=%0d perr=%b, required 2 1", seen, perr);
        end
        @(posedge clk); #1;
        cke = 1'b0;
        m_avalid = 1'b1; m_addr = 32'h400; m_wstrb = 4'h0;
        repeat (3) begin
            @(posedge clk); #1;
        end
        m_avalid = 1'b0; cke = 1'b1;
        do_req(32'h8000_0400, 32'h0, 4'h0, 10, w);
        tests_run++;
        if (w != 0) begin
            fails++;
            $display("FAIL cke_freeze: waited %0d cycles, required 0", w);
        end
        wait_drain(40);
    endtask

    initial begin
        #200000;
        fails++;
        $display("FAIL watchdog: simulation time limit reached, required completion");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_back_to_back();
        test_max_out();
        test_switch();
        test_decode_err();
        test_write_stray();
        test_reset_mid();
        repeat (2) @(posedge clk);
        $display("[TB] %0d tests run, %0d failed", tests_run, fails);
        $finish;
    end

endmodule
`default_nettype wire
